alu_issue_unit: RTL and testbench

- Decode/issue stage that drives the combinational ALU (ports iDataA, iDataB, iFunct3, iFunct7 -> oData, oZero) from RV32I OP (0110011) and OP-IMM (0010011) instructions.
- Accepts instruction plus register operands over a valid/ready handshake and forms ALU operands, including sign-extended immediates and masked shift amounts.
- Registers the ALU result and returns it to the writeback side over a second valid/ready handshake.
- This is the initiator end of the ALU interface; the ALU stays purely combinational and is instantiated inside this block.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_issue_unit_if.sv | 28 ++
 rtl/alu.sv | 44 ++++
 rtl/alu_operand_decode.sv | 63 ++++++
 rtl/alu_issue_unit.sv | 101 ++++++++++
 tb/tb_alu_issue_unit.sv | 387 ++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared constants, decoded-op bundle and helpers for the ALU issue unit.
// Imported by the decode, ALU, interface and top-level files.
package alu_pkg;

    localparam int ALU_XLEN    = 32;
    localparam int ALU_SHAMT_W = 5;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [ALU_XLEN-1:0] a;
        logic [ALU_XLEN-1:0] b;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [4:0]          rd;
        logic                illegal;
    } dec_op_t;

    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == F3_SLL) || (f3 == F3_SRL);
    endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Instruction-in / result-out handshake bundle of the ALU issue unit.
// slave: the issue unit side; master: the decode/writeback side driving it.
interface alu_issue_unit_if;
    import alu_pkg::*;

    logic                iInstValid;
    logic                oInstReady;
    logic [31:0]         iInst;
    logic [ALU_XLEN-1:0] iRs1Data;
    logic [ALU_XLEN-1:0] iRs2Data;
    logic                oResValid;
    logic                iResReady;
    logic [ALU_XLEN-1:0] oResData;
    logic                oResZero;
    logic [4:0]          oResRd;
    logic                oIllegal;

    modport slave (
        input  iInstValid, iInst, iRs1Data, iRs2Data, iResReady,
        output oInstReady, oResValid, oResData, oResZero, oResRd, oIllegal
    );

    modport master (
        output iInstValid, iInst, iRs1Data, iRs2Data, iResReady,
        input  oInstReady, oResValid, oResData, oResZero, oResRd, oIllegal
    );

endinterface

// File: rtl/alu.sv
// Combinational RV32I integer ALU.
// Ports: iDataA/iDataB operands, iFunct3/iFunct7 op select -> oData, oZero.
module alu
    import alu_pkg::*;
(
    input  logic [ALU_XLEN-1:0] iDataA,
    input  logic [ALU_XLEN-1:0] iDataB,
    input  logic [2:0]          iFunct3,
    input  logic [6:0]          iFunct7,
    output logic [ALU_XLEN-1:0] oData,
    output logic                oZero
);

    logic                   alt;
    logic [ALU_SHAMT_W-1:0] sh;
    logic                   unused_f7;

    assign alt       = iFunct7[5];
    assign sh        = iDataB[ALU_SHAMT_W-1:0];
    assign unused_f7 = ^{iFunct7[6], iFunct7[4:0]};

    always_comb begin
        oData = '0;
        unique case (iFunct3)
            F3_ADD:  oData = alt ? (iDataA - iDataB) : (iDataA + iDataB);
            F3_SLL:  oData = iDataA << sh;
            F3_SLT:  oData = {{(ALU_XLEN-1){1'b0}},
                              $signed(iDataA) < $signed(iDataB)};
            F3_SLTU: oData = {{(ALU_XLEN-1){1'b0}}, iDataA < iDataB};
            F3_XOR:  oData = iDataA ^ iDataB;
            F3_SRL: begin
                // kept out of a ?: so the arithmetic shift stays signed
                if (alt) oData = $unsigned($signed(iDataA) >>> sh);
                else     oData = iDataA >> sh;
            end
            F3_OR:   oData = iDataA | iDataB;
            F3_AND:  oData = iDataA & iDataB;
            default: oData = '0;
        endcase
    end

    assign oZero = (oData == '0);

endmodule

// File: rtl/alu_operand_decode.sv
// Combinational OP/OP-IMM decode into ALU operands and legality flag.
// Ports: iInst, iRs1Data, iRs2Data -> oDec (a, b, funct3, funct7, rd, illegal).
module alu_operand_decode
    import alu_pkg::*;
#(
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic [31:0]         iInst,
    input  logic [ALU_XLEN-1:0] iRs1Data,
    input  logic [ALU_XLEN-1:0] iRs2Data,
    output dec_op_t             oDec
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_op;
    logic       is_imm;
    logic       shift;
    logic       f7_alt_ok;
    logic       unused_rs1_field;

    assign opc    = iInst[6:0];
    assign f3     = iInst[14:12];
    assign f7     = iInst[31:25];
    assign is_op  = (opc == OPC_OP);
    assign is_imm = (opc == OPC_OPIMM);
    assign shift  = is_shift(f3);

    // rs1 arrives as data; the register index itself is not needed here
    assign unused_rs1_field = ^iInst[19:15];

    always_comb begin
        oDec        = '0;
        oDec.a      = iRs1Data;
        oDec.rd     = iInst[11:7];
        oDec.funct3 = f3;
        f7_alt_ok   = 1'b0;
        unique case (1'b1)
            is_op: begin
                f7_alt_ok   = (f3 == F3_ADD) || (f3 == F3_SRL);
                oDec.funct7 = f7;
                oDec.b      = shift
                    ? {{(ALU_XLEN-SHAMT_W){1'b0}}, iRs2Data[SHAMT_W-1:0]}
                    : iRs2Data;
                oDec.illegal = !((f7 == F7_BASE) ||
                                 ((f7 == F7_ALT) && f7_alt_ok));
            end
            is_imm: begin
                f7_alt_ok = (f3 == F3_SRL);
                // only SRLI/SRAI carry funct7; ADDI etc. must never see SUB
                oDec.funct7 = (f3 == F3_SRL) ? f7 : F7_BASE;
                oDec.b      = shift
                    ? {{(ALU_XLEN-SHAMT_W){1'b0}}, iInst[20 +: SHAMT_W]}
                    : {{(ALU_XLEN-12){iInst[31]}}, iInst[31:20]};
                oDec.illegal = shift &&
                    !((f7 == F7_BASE) || ((f7 == F7_ALT) && f7_alt_ok));
            end
            default: oDec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Two-stage issue unit: S1 holds decoded ALU operands, S2 holds the result.
// Ports: iClk, iRstN (async active-low), bus (alu_issue_unit_if.slave).
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              iClk,
    input  logic              iRstN,
    alu_issue_unit_if.slave   bus
);

    dec_op_t   dec;
    dec_op_t   s1_q, s1_d;
    logic      s1_valid_q, s1_valid_d;
    logic      s2_valid_q, s2_valid_d;
    logic [XLEN-1:0] res_data_q, res_data_d;
    logic      res_zero_q, res_zero_d;
    logic [4:0] res_rd_q, res_rd_d;
    logic      res_ill_q, res_ill_d;
    logic      rdy_en_q;

    logic      s2_free;
    logic      s1_adv;
    logic      inst_ready;
    logic      accept;
    logic [XLEN-1:0] alu_data;
    logic      alu_zero;

    alu_operand_decode #(
        .SHAMT_W (SHAMT_W)
    ) u_dec (
        .iInst    (bus.iInst),
        .iRs1Data (bus.iRs1Data),
        .iRs2Data (bus.iRs2Data),
        .oDec     (dec)
    );

    alu u_alu (
        .iDataA  (s1_q.a),
        .iDataB  (s1_q.b),
        .iFunct3 (s1_q.funct3),
        .iFunct7 (s1_q.funct7),
        .oData   (alu_data),
        .oZero   (alu_zero)
    );

    always_comb begin
        s2_free    = !s2_valid_q || bus.iResReady;
        s1_adv     = s1_valid_q && s2_free;
        // rdy_en_q keeps ready low until the first edge after reset
        inst_ready = rdy_en_q && (!s1_valid_q || s1_adv);
        accept     = bus.iInstValid && inst_ready;

        s1_d       = accept ? dec : s1_q;
        s1_valid_d = accept || (s1_valid_q && !s1_adv);
        s2_valid_d = s1_adv || (s2_valid_q && !bus.iResReady);

        res_data_d = res_data_q;
        res_zero_d = res_zero_q;
        res_rd_d   = res_rd_q;
        res_ill_d  = res_ill_q;
        if (s1_adv) begin
            res_data_d = s1_q.illegal ? '0 : alu_data;
            res_zero_d = s1_q.illegal ? 1'b1 : alu_zero;
            res_rd_d   = s1_q.rd;
            res_ill_d  = s1_q.illegal;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            rdy_en_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            res_data_q <= '0;
            res_zero_q <= 1'b0;
            res_rd_q   <= '0;
            res_ill_q  <= 1'b0;
        end else begin
            rdy_en_q   <= 1'b1;
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            res_data_q <= res_data_d;
            res_zero_q <= res_zero_d;
            res_rd_q   <= res_rd_d;
            res_ill_q  <= res_ill_d;
        end
    end

    assign bus.oInstReady = inst_ready;
    assign bus.oResValid  = s2_valid_q;
    assign bus.oResData   = res_data_q;
    assign bus.oResZero   = res_zero_q;
    assign bus.oResRd     = res_rd_q;
    assign bus.oIllegal   = res_ill_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: directed vectors, corner sequences
// and a randomized stream against a behavioural reference model.
module tb_alu_issue_unit;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_unit_if bus ();

    alu_issue_unit #(
        .XLEN    (32),
        .SHAMT_W (5)
    ) dut (
        .iClk  (clk),
        .iRstN (rst_n),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] data;
        logic        zero;
        logic [4:0]  rd;
        logic        ill;
    } res_t;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] data;
        logic        zero;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7,
        input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3,
        input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm,
        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd,
        input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    // Reference: RV32I OP/OP-IMM semantics computed directly from the ISA.
    function automatic res_t model(input logic [31:0] inst,
        input logic [31:0] a, input logic [31:0] rs2);
        res_t r;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] b;
        int sh;
        bit legal;
        bit alt;
        opc = inst[6:0];
        f3 = inst[14:12];
        f7 = inst[31:25];
        r.rd = inst[11:7];
        r.ill = 1'b0;
        r.data = 32'h0;
        legal = 1'b0;
        alt = 1'b0;
        b = 32'h0;
        sh = 0;
        if (opc == 7'b0110011) begin
            b = rs2;
            sh = int'(rs2 % 32);
            alt = (f7 == 7'h20);
            legal = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
        end else if (opc == 7'b0010011) begin
            b = {{20{inst[31]}}, inst[31:20]};
            sh = int'(inst[24:20]);
            alt = (f3 == 3'd5) && (f7 == 7'h20);
            legal = !(f3 == 3'd1 || f3 == 3'd5) || (f7 == 7'h00) || alt;
        end
        if (!legal) begin
            r.ill = 1'b1;
            r.data = 32'h0;
            r.zero = 1'b1;
            return r;
        end
        case (f3)
            3'd0: r.data = (alt && opc == 7'b0110011) ? a - b : a + b;
            3'd1: r.data = a << sh;
            3'd2: r.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r.data = (a < b) ? 32'd1 : 32'd0;
            3'd4: r.data = a ^ b;
            3'd5: begin
                if (alt) r.data = $signed(a) >>> sh;
                else     r.data = a >> sh;
            end
            3'd6: r.data = a | b;
            default: r.data = a & b;
        endcase
        r.zero = (r.data == 32'h0);
        return r;
    endfunction

    task automatic issue_one(input vec_t v);
        int guard;
        int lat;
        bit done;
        @(negedge clk);
        bus.iInstValid = 1'b1;
        bus.iInst = v.inst;
        bus.iRs1Data = v.rs1;
        bus.iRs2Data = v.rs2;
        #1;
        guard = 0;
        while (!bus.oInstReady && guard < 10) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk({v.name, "_ready"}, 32'(bus.oInstReady), 32'd1);
        if (!bus.oInstReady) begin
            bus.iInstValid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.iInstValid = 1'b0;
        lat = 1;
        done = 1'b0;
        while (!done && lat < 10) begin
            @(negedge clk);
            if (bus.oResValid) done = 1'b1;
            else lat++;
        end
        chk({v.name, "_lat"}, 32'(lat), 32'd2);
        chk({v.name, "_data"}, bus.oResData, v.data);
        chk({v.name, "_zero"}, 32'(bus.oResZero), 32'(v.zero));
        chk({v.name, "_rd"}, 32'(bus.oResRd), 32'(v.rd));
        chk({v.name, "_ill"}, 32'(bus.oIllegal), 32'(v.ill));
        @(negedge clk);
        chk({v.name, "_nodup"}, 32'(bus.oResValid), 32'd0);
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [31:0] inst;
        int r;
        int s;
        inst = $urandom;
        r = $urandom_range(0, 9);
        if (r < 4)      inst[6:0] = OPC_OP;
        else if (r < 8) inst[6:0] = OPC_OPIMM;
        s = $urandom_range(0, 3);
        if (s == 0)      inst[31:25] = F7_BASE;
        else if (s == 1) inst[31:25] = F7_ALT;
        else if (s == 2) inst[31:25] = 7'h00;
        return inst;
    endfunction

    vec_t vecs[8];
    logic [31:0] bp_inst[3];
    logic [31:0] bp_exp[3];
    res_t q[$];

    initial begin
        int idx;
        int got;
        int seen;
        bit fire;
        bit holding;
        bit prev_stall;
        logic [31:0] prev_data;
        logic [31:0] cur_inst;
        logic [31:0] cur_rs1;
        logic [31:0] cur_rs2;
        res_t e;

        vecs[0] = '{"slli", enc_i(12'h002, 5'd1, 3'd1, 5'd5, OPC_OPIMM),
                    32'h7, 32'h0, 32'h1C, 1'b0, 5'd5, 1'b0};
        vecs[1] = '{"srai", enc_i(12'h401, 5'd1, 3'd5, 5'd6, OPC_OPIMM),
                    32'h80000000, 32'h0, 32'hC0000000, 1'b0, 5'd6, 1'b0};
        vecs[2] = '{"srli", enc_i(12'h001, 5'd1, 3'd5, 5'd7, OPC_OPIMM),
                    32'h80000000, 32'h0, 32'h40000000, 1'b0, 5'd7, 1'b0};
        vecs[3] = '{"sll_mask", enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd8, OPC_OP),
                    32'h0000FFFF, 32'd35, 32'h0007FFF8, 1'b0, 5'd8, 1'b0};
        vecs[4] = '{"addi_400", enc_i(12'h400, 5'd1, 3'd0, 5'd9, OPC_OPIMM),
                    32'h10, 32'h0, 32'h410, 1'b0, 5'd9, 1'b0};
        vecs[5] = '{"sub_zero", enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd10, OPC_OP),
                    32'd5, 32'd5, 32'h0, 1'b1, 5'd10, 1'b0};
        vecs[6] = '{"ill_load", enc_i(12'h004, 5'd1, 3'd2, 5'd11, 7'b0000011),
                    32'h1234, 32'h0, 32'h0, 1'b1, 5'd11, 1'b1};
        vecs[7] = '{"ill_f7", enc_r(7'h20, 5'd2, 5'd1, 3'd1, 5'd12, OPC_OP),
                    32'h1, 32'h1, 32'h0, 1'b1, 5'd12, 1'b1};

        bus.iInstValid = 1'b0;
        bus.iInst = 32'h0;
        bus.iRs1Data = 32'h0;
        bus.iRs2Data = 32'h0;
        bus.iResReady = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.oInstReady), 32'd0);
        chk("rst_valid", 32'(bus.oResValid), 32'd0);
        chk("rst_data", bus.oResData, 32'h0);
        chk("rst_ill", 32'(bus.oIllegal), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_ready", 32'(bus.oInstReady), 32'd0);
        @(negedge clk);
        chk("rst_ready_up", 32'(bus.oInstReady), 32'd1);

        for (int i = 0; i < 8; i++) issue_one(vecs[i]);

        // back-to-back SRAI then SRLI
        @(negedge clk);
        bus.iInstValid = 1'b1;
        bus.iInst = vecs[1].inst;
        bus.iRs1Data = 32'h80000000;
        #1;
        chk("b2b_rdy0", 32'(bus.oInstReady), 32'd1);
        @(negedge clk);
        bus.iInst = vecs[2].inst;
        #1;
        chk("b2b_rdy1", 32'(bus.oInstReady), 32'd1);
        @(negedge clk);
        bus.iInstValid = 1'b0;
        chk("b2b_v0", 32'(bus.oResValid), 32'd1);
        chk("b2b_d0", bus.oResData, 32'hC0000000);
        @(negedge clk);
        chk("b2b_v1", 32'(bus.oResValid), 32'd1);
        chk("b2b_d1", bus.oResData, 32'h40000000);
        @(negedge clk);
        chk("b2b_end", 32'(bus.oResValid), 32'd0);

        // backpressure: 3 offered, 4 stalled cycles
        for (int i = 0; i < 3; i++) begin
            bp_inst[i] = enc_i(12'(i + 1), 5'd3, 3'd0, 5'(i + 1), OPC_OPIMM);
            bp_exp[i] = 32'(100 * (i + 1) + i + 1);
        end
        bus.iResReady = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.iInstValid = (idx < 3);
            if (idx < 3) begin
                bus.iInst = bp_inst[idx];
                bus.iRs1Data = 32'(100 * (idx + 1));
            end
            #1;
            fire = bus.iInstValid && bus.oInstReady;
            if (c >= 2) begin
                chk("bp_ready", 32'(bus.oInstReady), 32'd0);
                chk("bp_valid", 32'(bus.oResValid), 32'd1);
                chk("bp_hold", bus.oResData, bp_exp[0]);
            end
            @(posedge clk);
            if (fire) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        got = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus.iResReady = 1'b1;
            bus.iInstValid = (idx < 3);
            if (idx < 3) begin
                bus.iInst = bp_inst[idx];
                bus.iRs1Data = 32'(100 * (idx + 1));
            end
            #1;
            if (bus.oResValid) begin
                if (got < 3) chk("bp_order", bus.oResData, bp_exp[got]);
                got++;
            end
            fire = bus.iInstValid && bus.oInstReady;
            @(posedge clk);
            if (fire) idx++;
        end
        chk("bp_count", 32'(got), 32'd3);

        // reset mid-stream
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.iInstValid = 1'b1;
            bus.iInst = bp_inst[c];
            bus.iRs1Data = 32'h55;
        end
        @(negedge clk);
        rst_n = 1'b0;
        bus.iInstValid = 1'b0;
        #1;
        chk("mrst_valid", 32'(bus.oResValid), 32'd0);
        chk("mrst_ready", 32'(bus.oInstReady), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (bus.oResValid) seen++;
        end
        chk("mrst_emitted", 32'(seen), 32'd0);
        chk("mrst_ready_up", 32'(bus.oInstReady), 32'd1);

        // randomized stream against the model
        holding = 1'b0;
        prev_stall = 1'b0;
        prev_data = 32'h0;
        cur_inst = 32'h0;
        cur_rs1 = 32'h0;
        cur_rs2 = 32'h0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (!holding) begin
                cur_inst = rnd_inst();
                cur_rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9))
                                                      : $urandom;
                cur_rs2 = ($urandom_range(0, 3) == 0) ? cur_rs1 : $urandom;
                bus.iInstValid = ($urandom_range(0, 9) < 7);
            end
            bus.iInst = cur_inst;
            bus.iRs1Data = cur_rs1;
            bus.iRs2Data = cur_rs2;
            bus.iResReady = ($urandom_range(0, 9) < 6);
            #1;
            if (prev_stall) begin
                chk("rnd_hold_v", 32'(bus.oResValid), 32'd1);
                chk("rnd_hold_d", bus.oResData, prev_data);
            end
            if (bus.oResValid && bus.iResReady) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", 32'(bus.oResValid), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_data", bus.oResData, e.data);
                    chk("rnd_zero", 32'(bus.oResZero), 32'(e.zero));
                    chk("rnd_rd", 32'(bus.oResRd), 32'(e.rd));
                    chk("rnd_ill", 32'(bus.oIllegal), 32'(e.ill));
                end
            end
            prev_stall = bus.oResValid && !bus.iResReady;
            prev_data = bus.oResData;
            if (bus.iInstValid && bus.oInstReady)
                q.push_back(model(cur_inst, cur_rs1, cur_rs2));
            holding = bus.iInstValid && !bus.oInstReady;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.iInstValid = 1'b0;
            bus.iResReady = 1'b1;
            #1;
            if (bus.oResValid) begin
                if (q.size() == 0) begin
                    chk("drain_spurious", 32'(bus.oResValid), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("drain_data", bus.oResData, e.data);
                    chk("drain_ill", 32'(bus.oIllegal), 32'(e.ill));
                end
            end
        end
        chk("drain_left", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
